// File: rtl/hdbn_encoder_if.sv
// Bit-source / line-driver side of the HDBn encoder.
// The source drives the i_* signals; the encoder returns ternary symbols on o_*.
interface hdbn_encoder_if;
    logic       i_data;       // binary input bit
    logic       i_valid;      // i_data is accepted on this rising edge
    logic       i_mode;       // 1 = HDBn substitution, 0 = plain AMI
    logic [1:0] o_hdb3_code;  // 00 = 0, 01 = +1, 10 = -1
    logic       o_valid;      // new symbol this cycle (one-cycle strobe)
    logic       o_v_flag;     // current symbol is a violation pulse
    logic       o_b_flag;     // current symbol is an inserted B pulse

    // Bit source / stimulus side
    modport master (
        output i_data, i_valid, i_mode,
        input  o_hdb3_code, o_valid, o_v_flag, o_b_flag
    );

    // Encoder side
    modport slave (
        input  i_data, i_valid, i_mode,
        output o_hdb3_code, o_valid, o_v_flag, o_b_flag
    );
endinterface

// File: rtl/hdbn_encoder.sv
// HDBn line encoder with configurable zero-run limit (HDB3 at N_ZERO=4,
// B3ZS-style at N_ZERO=3) and a plain AMI bypass mode.
//
// Every accepted bit enters an N_ZERO-deep look-ahead pipeline. When the
// N_ZERO-th consecutive zero arrives, the new slot is marked V and, if the
// number of pulses since the last violation is even, the first zero of the
// run (the slot about to reach the pipeline end) is marked B. The slot that
// leaves the pipeline is turned into a ternary symbol using the running
// polarity. Symbol for accepted bit k is presented with accept k+N_ZERO.
//
// N_ZERO must lie in 2..16 and 2**CNT_W must exceed N_ZERO.
module hdbn_encoder #(
    parameter int N_ZERO = 4,
    parameter int CNT_W  = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    hdbn_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_POS  = 2'b01,
        SYM_NEG  = 2'b10
    } sym_t;

    // One pipeline slot: the original bit plus the substitution marks.
    typedef struct packed {
        logic data;
        logic b;
        logic v;
    } slot_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_ZERO);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(N_ZERO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Registered state and its next-state values
    slot_t [N_ZERO-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   zc_q, zc_d;
    logic               last_pos_q, last_pos_d;  // 1 = last non-V pulse was +1
    logic               parity_q, parity_d;      // pulses since last V, mod 2
    sym_t               code_q, code_d;
    logic               valid_q, valid_d;
    logic               v_flag_q, v_flag_d;
    logic               b_flag_q, b_flag_d;

    // Per-accept working signals
    logic  accept;
    logic  full;
    slot_t exit_slot;
    logic  exit_pulse;
    slot_t new_slot;
    logic  insert_b;

    assign accept     = bus.i_valid;
    assign full       = (fill_q == FULL_CNT);
    assign exit_slot  = sr_q[N_ZERO-1];
    assign exit_pulse = exit_slot.data | exit_slot.b;

    // Output stage: encode the exiting slot and advance polarity / parity
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        code_d     = code_q;
        v_flag_d   = v_flag_q;
        b_flag_d   = b_flag_q;
        valid_d    = 1'b0;
        last_pos_d = last_pos_q;
        parity_d   = parity_q;
        fill_d     = fill_q;

        if (accept) begin
            if (full) begin
                valid_d  = 1'b1;
                code_d   = SYM_ZERO;
                v_flag_d = 1'b0;
                b_flag_d = 1'b0;
                if (exit_pulse) begin
                    // Ordinary mark or B pulse: alternate polarity.
                    code_d     = last_pos_q ? SYM_NEG : SYM_POS;
                    last_pos_d = ~last_pos_q;
                    parity_d   = ~parity_q;
                    b_flag_d   = exit_slot.b;
                end else if (exit_slot.v) begin
                    // Violation repeats the previous polarity and restarts
                    // the pulse parity for the next substitution.
                    code_d   = last_pos_q ? SYM_POS : SYM_NEG;
                    v_flag_d = 1'b1;
                    parity_d = 1'b0;
                end
            end else begin
                fill_d = fill_q + CNT_ONE;
            end
        end
    end

    // Input stage: zero-run counting and substitution decision
    always_comb begin
        zc_d          = zc_q;
        new_slot      = '0;
        new_slot.data = bus.i_data;
        insert_b      = 1'b0;

        if (accept) begin
            if (bus.i_data || !bus.i_mode) begin
                // A mark, or AMI mode, ends (and discards) any partial run.
                zc_d = '0;
            end else if (zc_q == RUN_LAST) begin
                new_slot.v = 1'b1;
                zc_d       = '0;
                // parity_d already accounts for the slot leaving this cycle,
                // including a V that clears the parity as it exits.
                insert_b   = ~parity_d;
            end else begin
                zc_d = zc_q + CNT_ONE;
            end
        end
    end

    // Pipeline shift: new bit enters slot 0, the first zero of a
    // substituted run lands in the last slot carrying its B mark
    always_comb begin
        sr_d = sr_q;
        if (accept) begin
            sr_d = {sr_q[N_ZERO-2:0], new_slot};
            if (insert_b) begin
                sr_d[N_ZERO-1].b = 1'b1;
            end
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the look-ahead pipeline is reset too, because stale marks
            // left in it would otherwise corrupt the first substitution.
            sr_q       <= '0;
            fill_q     <= '0;
            zc_q       <= '0;
            last_pos_q <= 1'b0;
            parity_q   <= 1'b0;
            code_q     <= SYM_ZERO;
            valid_q    <= 1'b0;
            v_flag_q   <= 1'b0;
            b_flag_q   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so all registers update together at the edge.
            sr_q       <= sr_d;
            fill_q     <= fill_d;
            zc_q       <= zc_d;
            last_pos_q <= last_pos_d;
            parity_q   <= parity_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            v_flag_q   <= v_flag_d;
            b_flag_q   <= b_flag_d;
        end
    end

    assign bus.o_hdb3_code = code_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_v_flag    = v_flag_q;
    assign bus.o_b_flag    = b_flag_q;

endmodule

// File: tb/tb_hdbn_encoder.sv
// Directed self-checking bench for hdbn_encoder at N_ZERO=4 (HDB3).
// Symbols are captured as {code, v_flag, b_flag} whenever o_valid is high
// and compared against hand-derived sequences.
module tb_hdbn_encoder;

    localparam logic [3:0] E_Z  = 4'b0000;  // 00
    localparam logic [3:0] E_P  = 4'b0100;  // +1
    localparam logic [3:0] E_N  = 4'b1000;  // -1
    localparam logic [3:0] E_PB = 4'b0101;  // +1 B
    localparam logic [3:0] E_NB = 4'b1001;  // -1 B
    localparam logic [3:0] E_PV = 4'b0110;  // +1 V
    localparam logic [3:0] E_NV = 4'b1010;  // -1 V

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [3:0] got[$];

    hdbn_encoder_if dut_if ();

    hdbn_encoder #(
        .N_ZERO(4),
        .CNT_W (5)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic d, input logic v, input logic m);
        @(negedge clk);
        dut_if.i_data  = d;
        dut_if.i_valid = v;
        dut_if.i_mode  = m;
        @(posedge clk);
        #1;
        if (dut_if.o_valid)
            got.push_back({dut_if.o_hdb3_code, dut_if.o_v_flag, dut_if.o_b_flag});
    endtask

    // Feed n bits, MSB of the used range first, all valid.
    task automatic feed(input logic [31:0] bits, input int n, input logic m);
        for (int i = n - 1; i >= 0; i--)
            step(bits[i], 1'b1, m);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst            = 1'b1;
        dut_if.i_valid = 1'b0;
        dut_if.i_data  = 1'b0;
        dut_if.i_mode  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst            = 1'b1;
        dut_if.i_valid = 1'b1;
        dut_if.i_data  = 1'b1;
        dut_if.i_mode  = 1'b1;
        #1;
        n_cmp++;
        if (dut_if.o_hdb3_code !== 2'b00) begin
            $display("FAIL reset_code: got %b expected 00", dut_if.o_hdb3_code);
            n_bad++;
        end
        // An edge with i_valid high must not move anything while in reset.
        @(posedge clk);
        #1;
        n_cmp++;
        if ({dut_if.o_valid, dut_if.o_v_flag, dut_if.o_b_flag} !== 3'b000) begin
            $display("FAIL reset_flags: got valid/v/b=%b expected 000",
                     {dut_if.o_valid, dut_if.o_v_flag, dut_if.o_b_flag});
            n_bad++;
        end
        apply_reset();
    endtask

    task automatic test_all_ones;
        logic [3:0] exp_q[$];
        int first_valid;
        apply_reset();
        first_valid = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (first_valid < 0 && got.size() > 0)
                first_valid = i;
        end
        n_cmp++;
        if (first_valid !== 5) begin
            $display("FAIL ones_latency: got first o_valid after accept %0d expected 5", first_valid);
            n_bad++;
        end
        exp_q = '{E_P, E_N, E_P, E_N};
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL ones_count: got %0d symbols expected %0d", got.size(), exp_q.size());
            n_bad++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                $display("FAIL ones_sym%0d: got %b expected %b", i, got[i], exp_q[i]);
                n_bad++;
            end
        end
    endtask

    task automatic test_zero_runs;
        logic [3:0] exp_q[$];
        apply_reset();
        feed(32'b0000_0000_1111, 12, 1'b1);
        exp_q = '{E_PB, E_Z, E_Z, E_PV, E_NB, E_Z, E_Z, E_NV};
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL runs_count: got %0d symbols expected %0d", got.size(), exp_q.size());
            n_bad++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                $display("FAIL runs_sym%0d: got %b expected %b", i, got[i], exp_q[i]);
                n_bad++;
            end
        end
    endtask

    task automatic test_odd_parity;
        logic [3:0] exp_q[$];
        apply_reset();
        feed(32'b1_0000_1111_1111, 13, 1'b1);
        exp_q = '{E_P, E_Z, E_Z, E_Z, E_PV, E_N, E_P, E_N, E_P};
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL odd_count: got %0d symbols expected %0d", got.size(), exp_q.size());
            n_bad++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                $display("FAIL odd_sym%0d: got %b expected %b", i, got[i], exp_q[i]);
                n_bad++;
            end
        end
    endtask

    // Runs of N_ZERO-1 zeros must pass through untouched.
    task automatic test_short_runs;
        logic [3:0] exp_q[$];
        apply_reset();
        feed(32'b1_0001_0001_0000, 13, 1'b1);
        exp_q = '{E_P, E_Z, E_Z, E_Z, E_N, E_Z, E_Z, E_Z, E_P};
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL short_count: got %0d symbols expected %0d", got.size(), exp_q.size());
            n_bad++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                $display("FAIL short_sym%0d: got %b expected %b", i, got[i], exp_q[i]);
                n_bad++;
            end
        end
    endtask

    task automatic test_ami;
        logic [3:0] exp_q[$];
        apply_reset();
        feed(32'b0000_0000_1100_00, 14, 1'b0);
        exp_q = '{E_Z, E_Z, E_Z, E_Z, E_Z, E_Z, E_Z, E_Z, E_P, E_N};
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL ami_count: got %0d symbols expected %0d", got.size(), exp_q.size());
            n_bad++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                $display("FAIL ami_sym%0d: got %b expected %b", i, got[i], exp_q[i]);
                n_bad++;
            end
        end
    endtask

    // A zero sampled in AMI mode discards the partial run, so 2+1+3 zeros
    // produce no substitution.
    task automatic test_mode_switch;
        logic [3:0] exp_q[$];
        apply_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        feed(32'b1_1111, 5, 1'b1);
        exp_q = '{E_P, E_Z, E_Z, E_Z, E_Z, E_Z, E_Z, E_N};
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL modesw_count: got %0d symbols expected %0d", got.size(), exp_q.size());
            n_bad++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                $display("FAIL modesw_sym%0d: got %b expected %b", i, got[i], exp_q[i]);
                n_bad++;
            end
        end
    endtask

    task automatic test_gapped;
        logic [3:0]  exp_q[$];
        logic [11:0] bits;
        logic [3:0]  pv;
        logic [1:0]  held;
        logic        v;
        logic        exp_valid;
        int          acc;
        apply_reset();
        bits = 12'b0000_0000_1111;
        pv   = 4'b1001;
        held = 2'b00;
        acc  = 0;
        for (int c = 0; c < 100 && acc < 12; c++) begin
            v = pv[3 - (c % 4)];
            // Invalid cycles carry a 1 that must be ignored.
            step(v ? bits[11 - acc] : 1'b1, v, 1'b1);
            exp_valid = v && (acc >= 4);
            n_cmp++;
            if (dut_if.o_valid !== exp_valid) begin
                $display("FAIL gap_valid_c%0d: got %b expected %b", c, dut_if.o_valid, exp_valid);
                n_bad++;
            end
            if (dut_if.o_valid) begin
                held = dut_if.o_hdb3_code;
            end else begin
                n_cmp++;
                if (dut_if.o_hdb3_code !== held) begin
                    $display("FAIL gap_hold_c%0d: got %b expected %b", c, dut_if.o_hdb3_code, held);
                    n_bad++;
                end
            end
            if (v) acc++;
        end
        n_cmp++;
        if (acc != 12) begin
            $display("FAIL gap_budget: got %0d accepts expected 12", acc);
            n_bad++;
        end
        exp_q = '{E_PB, E_Z, E_Z, E_PV, E_NB, E_Z, E_Z, E_NV};
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            $display("FAIL gap_count: got %0d symbols expected %0d", got.size(), exp_q.size());
            n_bad++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                $display("FAIL gap_sym%0d: got %b expected %b", i, got[i], exp_q[i]);
                n_bad++;
            end
        end
    endtask

    task automatic test_async_reset;
        apply_reset();
        // Get a live +1 symbol on the outputs, then reset between edges.
        feed(32'b1_1111, 5, 1'b1);
        n_cmp++;
        if ({dut_if.o_hdb3_code, dut_if.o_valid} !== 3'b011) begin
            $display("FAIL areset_pre: got code/valid=%b expected 011",
                     {dut_if.o_hdb3_code, dut_if.o_valid});
            n_bad++;
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dut_if.o_hdb3_code, dut_if.o_valid, dut_if.o_v_flag, dut_if.o_b_flag} !== 5'b00000) begin
            $display("FAIL areset_live: got code/valid/v/b=%b expected 00000",
                     {dut_if.o_hdb3_code, dut_if.o_valid, dut_if.o_v_flag, dut_if.o_b_flag});
            n_bad++;
        end
        @(negedge clk);
        rst = 1'b0;

        // Zero-run stream interrupted during its third zero.
        got.delete();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        dut_if.i_data  = 1'b0;
        dut_if.i_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dut_if.o_hdb3_code, dut_if.o_valid, dut_if.o_v_flag, dut_if.o_b_flag} !== 5'b00000) begin
            $display("FAIL areset_run: got code/valid/v/b=%b expected 00000",
                     {dut_if.o_hdb3_code, dut_if.o_valid, dut_if.o_v_flag, dut_if.o_b_flag});
            n_bad++;
        end
        @(negedge clk);
        rst            = 1'b0;
        dut_if.i_valid = 1'b0;

        // No flush: nothing appears until five fresh accepts, first is +1.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, 1'b1);
            n_cmp++;
            if (dut_if.o_valid !== (i == 5)) begin
                $display("FAIL areset_lat%0d: got o_valid %b expected %b", i, dut_if.o_valid, (i == 5));
                n_bad++;
            end
        end
        n_cmp++;
        if ({dut_if.o_hdb3_code, dut_if.o_v_flag, dut_if.o_b_flag} !== E_P) begin
            $display("FAIL areset_first: got %b expected %b",
                     {dut_if.o_hdb3_code, dut_if.o_v_flag, dut_if.o_b_flag}, E_P);
            n_bad++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected summary before timeout");
        $fatal(1);
    end

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        dut_if.i_data  = 1'b0;
        dut_if.i_valid = 1'b0;
        dut_if.i_mode  = 1'b1;
        test_reset();
        test_all_ones();
        test_zero_runs();
        test_odd_parity();
        test_short_runs();
        test_ami();
        test_mode_switch();
        test_gapped();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
